// File: rtl/vga_rx_monitor_if.sv
// vga_rx_monitor_if: VGA pixel stream in, recovered coordinates/status out.
// master = stream source side, slave = receiving monitor.
interface vga_rx_monitor_if;
   logic        iVGA_HS;
   logic        iVGA_VS;
   logic        iVGA_BLANK;
   logic [7:0]  iVGA_R;
   logic [7:0]  iVGA_G;
   logic [7:0]  iVGA_B;
   logic [23:0] oColor;
   logic [10:0] oCurrent_X;
   logic [10:0] oCurrent_Y;
   logic        oPixel_Valid;
   logic        oFrame_Start;
   logic        oLock;
   logic        oErr;
   logic [11:0] oH_Period;
   logic [10:0] oV_Lines;

   modport master (
      output iVGA_HS, iVGA_VS, iVGA_BLANK,
      output iVGA_R, iVGA_G, iVGA_B,
      input  oColor, oCurrent_X, oCurrent_Y,
      input  oPixel_Valid, oFrame_Start, oLock, oErr,
      input  oH_Period, oV_Lines
   );

   modport slave (
      input  iVGA_HS, iVGA_VS, iVGA_BLANK,
      input  iVGA_R, iVGA_G, iVGA_B,
      output oColor, oCurrent_X, oCurrent_Y,
      output oPixel_Valid, oFrame_Start, oLock, oErr,
      output oH_Period, oV_Lines
   );
endinterface

// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: pixel-clock VGA receiver.
// Recovers X/Y, measures line/frame timing and locks to the active geometry.
module vga_rx_monitor #(
   parameter int H_ACT       = 1280,
   parameter int V_ACT       = 720,
   parameter int LOCK_FRAMES = 2,
   parameter int TIMEOUT     = 4095
) (
   input  logic            iCLK,
   input  logic            iRST_N,
   vga_rx_monitor_if.slave vga
);

   typedef enum logic [1:0] {
      SEARCH,
      CHECK,
      LOCKED
   } state_t;

   state_t      state, stateNxt;
   logic [2:0]  gf, gfNxt, gfInc;
   logic        s1Hs, s1Vs, s1Blank;
   logic        s2Hs, s2Vs, s2Blank;
   logic [23:0] s1Rgb, s2Rgb;
   logic [10:0] xCnt, yCnt, yNxt;
   logic [11:0] pCnt, pInc;
   logic        vsFallD;
   logic        hsFall, vsFall, actRise, actFall;
   logic        lineBad, frameOk, timeout;
   logic        errNxt, lockNxt, validNxt;

   assign hsFall  = s2Hs & ~s1Hs;
   assign vsFall  = s2Vs & ~s1Vs;
   assign actRise = ~s2Blank & s1Blank;
   assign actFall = s2Blank & ~s1Blank;

   // Y as seen by the frame check: a line ending with VS belongs to the old frame
   assign yNxt    = (actFall && yCnt != 11'h7ff) ? yCnt + 11'd1 : yCnt;
   assign pInc    = (pCnt == 12'hfff) ? pCnt : pCnt + 12'd1;
   assign gfInc   = gf + 3'd1;
   assign lineBad = actFall && (int'(xCnt) + 1 != H_ACT);
   assign frameOk = int'(yNxt) == V_ACT;
   assign timeout = int'(pCnt) == TIMEOUT;

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         s1Hs    <= 1'b1;
         s1Vs    <= 1'b1;
         s1Blank <= 1'b0;
         s1Rgb   <= '0;
         s2Hs    <= 1'b1;
         s2Vs    <= 1'b1;
         s2Blank <= 1'b0;
         s2Rgb   <= '0;
      end else begin
         s1Hs    <= vga.iVGA_HS;
         s1Vs    <= vga.iVGA_VS;
         s1Blank <= vga.iVGA_BLANK;
         s1Rgb   <= {vga.iVGA_R, vga.iVGA_G, vga.iVGA_B};
         s2Hs    <= s1Hs;
         s2Vs    <= s1Vs;
         s2Blank <= s1Blank;
         s2Rgb   <= s1Rgb;
      end
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state <= SEARCH;
         gf    <= '0;
      end else begin
         state <= stateNxt;
         gf    <= gfNxt;
      end
   end

   always_comb begin
      stateNxt = state;
      gfNxt    = gf;
      errNxt   = 1'b0;
      unique case (state)
         SEARCH: begin
            gfNxt = '0;
            if (vsFall) stateNxt = CHECK;
         end
         CHECK: begin
            if (timeout || lineBad) begin
               errNxt   = 1'b1;
               stateNxt = SEARCH;
               gfNxt    = '0;
            end else if (vsFall && frameOk) begin
               gfNxt = gfInc;
               if (int'(gfInc) >= LOCK_FRAMES) stateNxt = LOCKED;
            end else if (vsFall) begin
               gfNxt  = '0;
               errNxt = 1'b1;
            end
         end
         LOCKED: begin
            if (timeout || lineBad || (vsFall && !frameOk)) begin
               errNxt   = 1'b1;
               stateNxt = SEARCH;
               gfNxt    = '0;
            end
         end
         default: begin
            stateNxt = SEARCH;
            gfNxt    = '0;
         end
      endcase
   end

   always_comb begin
      lockNxt  = (stateNxt == LOCKED);
      validNxt = (state == LOCKED) & s2Blank;
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         xCnt             <= '0;
         yCnt             <= '0;
         pCnt             <= '0;
         vsFallD          <= 1'b0;
         vga.oColor       <= '0;
         vga.oCurrent_X   <= '0;
         vga.oCurrent_Y   <= '0;
         vga.oPixel_Valid <= 1'b0;
         vga.oFrame_Start <= 1'b0;
         vga.oLock        <= 1'b0;
         vga.oErr         <= 1'b0;
         vga.oH_Period    <= '0;
         vga.oV_Lines     <= '0;
      end else begin
         if (actRise) xCnt <= '0;
         else if (s1Blank && xCnt != 11'h7ff) xCnt <= xCnt + 11'd1;
         yCnt <= vsFall ? 11'd0 : yNxt;
         if (hsFall) begin
            pCnt          <= '0;
            vga.oH_Period <= pInc;
         end else begin
            pCnt <= pInc;
         end
         if (vsFall) vga.oV_Lines <= yNxt;
         vsFallD          <= vsFall;
         vga.oFrame_Start <= vsFallD;
         vga.oColor       <= s2Rgb;
         vga.oCurrent_X   <= xCnt;
         vga.oCurrent_Y   <= yCnt;
         vga.oPixel_Valid <= validNxt;
         vga.oLock        <= lockNxt;
         vga.oErr         <= errNxt;
      end
   end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb_vga_rx_monitor: directed frame sequences with random colours,
// checked each cycle against an event-level model of the receiver.
module tb_vga_rx_monitor;
   localparam int HA   = 8;
   localparam int VA   = 4;
   localparam int LF   = 2;
   localparam int TO   = 4095;
   localparam int LINE = 14;

   logic clk = 1'b0;
   logic rstN = 1'b0;
   always #5 clk = ~clk;

   vga_rx_monitor_if vif();

   vga_rx_monitor #(
      .H_ACT(HA),
      .V_ACT(VA),
      .LOCK_FRAMES(LF),
      .TIMEOUT(TO)
   ) dut (
      .iCLK(clk),
      .iRST_N(rstN),
      .vga(vif)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit armed = 0;
   int validCnt = 0;
   int errCnt = 0;

   // model: 0 searching, 1 checking, 2 locked
   int st, gf, run, ym, lastHs, hp, vl;
   bit pHs, pVs, pB;

   // expected outputs, indexed by the clock edge they become visible after
   bit          eErr[4], eLock[4], eVal[4], eFs[4];
   logic [23:0] eCol[4];
   int          eX[4], eY[4], eHp[4], eVl[4];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model(input bit hs, input bit vs, input bit b,
                        input logic [23:0] rgb);
      int i0, i1, i2, gap;
      bit hsF, vsF, aR, aF, err;
      i0 = cyc & 3;
      i1 = (cyc + 1) & 3;
      i2 = (cyc + 2) & 3;
      if (!rstN) begin
         st = 0; gf = 0; run = 0; ym = 0;
         lastHs = cyc - 1; hp = 0; vl = 0;
         pHs = 1; pVs = 1; pB = 0;
         for (int k = 0; k < 2; k++) begin
            eErr[(cyc + k) & 3] = 0;
            eLock[(cyc + k) & 3] = 0;
            eHp[(cyc + k) & 3] = 0;
            eVl[(cyc + k) & 3] = 0;
         end
         for (int k = 0; k < 3; k++) begin
            eVal[(cyc + k) & 3] = 0;
            eFs[(cyc + k) & 3] = 0;
         end
         eVal[i0] = 0;
         armed = 1;
         return;
      end
      hsF = pHs & !hs;
      vsF = pVs & !vs;
      aR  = !pB & b;
      aF  = pB & !b;
      err = 0;
      gap = cyc - lastHs - 1;
      if (gap > 4095) gap = 4095;
      if (aR) run = 0;
      if (b) run++;
      if (st != 0 && gap == TO) begin
         err = 1; st = 0;
      end else if (aF && st != 0 && run != HA) begin
         err = 1; st = 0;
      end
      if (aF) ym++;
      if (vsF) begin
         vl = ym;
         if (!err) begin
            if (st == 0) begin
               st = 1; gf = 0;
            end else if (st == 1) begin
               if (ym == VA) begin
                  gf++;
                  if (gf >= LF) st = 2;
               end else begin
                  gf = 0; err = 1;
               end
            end else if (ym != VA) begin
               err = 1; st = 0;
            end
         end
         ym = 0;
      end
      if (st == 0) gf = 0;
      if (hsF) begin
         hp = (cyc - lastHs > 4095) ? 4095 : cyc - lastHs;
         lastHs = cyc;
      end
      eErr[i1] = err;
      eLock[i1] = (st == 2);
      eHp[i1] = hp;
      eVl[i1] = vl;
      eVal[i2] = (st == 2) && b;
      eFs[i2] = vsF;
      eCol[i2] = rgb;
      eX[i2] = run - 1;
      eY[i2] = ym;
      pHs = hs; pVs = vs; pB = b;
   endtask

   task automatic checkOut();
      int i0;
      i0 = cyc & 3;
      if (!armed) return;
      if (vif.oPixel_Valid === 1'b1) validCnt++;
      if (vif.oErr === 1'b1) errCnt++;
      chk("err", vif.oErr, eErr[i0]);
      chk("lock", vif.oLock, eLock[i0]);
      chk("valid", vif.oPixel_Valid, eVal[i0]);
      chk("frame_start", vif.oFrame_Start, eFs[i0]);
      chk("h_period", vif.oH_Period, eHp[i0]);
      chk("v_lines", vif.oV_Lines, eVl[i0]);
      if (eVal[i0]) begin
         chk("color", vif.oColor, eCol[i0]);
         chk("cur_x", vif.oCurrent_X, eX[i0]);
         chk("cur_y", vif.oCurrent_Y, eY[i0]);
      end
   endtask

   task automatic step(input bit hs, input bit vs, input bit b,
                       input logic [23:0] rgb);
      vif.iVGA_HS = hs;
      vif.iVGA_VS = vs;
      vif.iVGA_BLANK = b;
      vif.iVGA_R = rgb[23:16];
      vif.iVGA_G = rgb[15:8];
      vif.iVGA_B = rgb[7:0];
      @(posedge clk);
      cyc++;
      model(hs, vs, b, rgb);
      #1;
      checkOut();
   endtask

   task automatic rstStep();
      rstN = 1'b0;
      step(1'b1, 1'b1, 1'b0, 24'h0);
      rstN = 1'b1;
   endtask

   task automatic pix(input int p, input int nAct, input bit vsL,
                      input int y, input bit pat);
      bit b;
      logic [23:0] c;
      b = (p < nAct);
      c = pat ? {8'(y), 8'(p), 8'h5a} : 24'($urandom);
      step(!(p == 10 || p == 11), !vsL, b, b ? c : 24'h0);
   endtask

   task automatic line(input int nAct, input bit vsL, input int y,
                       input bit pat);
      for (int p = 0; p < LINE; p++) pix(p, nAct, vsL, y, pat);
   endtask

   task automatic frame(input int nLines, input int shortAt, input bit pat);
      for (int l = 0; l < nLines + 4; l++) begin
         line(l < nLines ? (l == shortAt ? HA - 1 : HA) : 0,
              (l == nLines + 1) || (l == nLines + 2), l, pat);
      end
   endtask

   task automatic rstZero(input string tag);
      chk({tag, "_color"}, vif.oColor, 0);
      chk({tag, "_x"}, vif.oCurrent_X, 0);
      chk({tag, "_y"}, vif.oCurrent_Y, 0);
      chk({tag, "_hper"}, vif.oH_Period, 0);
      chk({tag, "_vl"}, vif.oV_Lines, 0);
      chk({tag, "_lock"}, vif.oLock, 0);
      chk({tag, "_valid"}, vif.oPixel_Valid, 0);
   endtask

   initial begin
      vif.iVGA_HS = 1'b1;
      vif.iVGA_VS = 1'b1;
      vif.iVGA_BLANK = 1'b0;
      vif.iVGA_R = 8'h0;
      vif.iVGA_G = 8'h0;
      vif.iVGA_B = 8'h0;
      repeat (3) rstStep();
      rstZero("reset");

      frame(VA, -1, 1'b1);
      frame(VA, -1, 1'b0);
      chk("lock_early", vif.oLock, 0);
      frame(VA, -1, 1'b1);
      chk("lock_3f", vif.oLock, 1);
      chk("hper_14", vif.oH_Period, 14);
      chk("vlines_4", vif.oV_Lines, 4);
      validCnt = 0;
      frame(VA, -1, 1'b1);
      chk("valid_32", validCnt, 32);
      validCnt = 0;
      frame(VA, -1, 1'b0);
      chk("valid_32_rnd", validCnt, 32);

      errCnt = 0;
      frame(VA, 2, 1'b1);
      chk("short_err", errCnt, 1);
      chk("short_unlock", vif.oLock, 0);
      frame(VA, -1, 1'b0);
      chk("relock_wait", vif.oLock, 0);
      frame(VA, -1, 1'b1);
      chk("relock", vif.oLock, 1);

      errCnt = 0;
      repeat (4200) step(1'b1, 1'b1, 1'b0, 24'h0);
      chk("to_err", errCnt, 1);
      chk("to_unlock", vif.oLock, 0);
      line(0, 1'b0, 0, 1'b0);
      chk("hper_sat", vif.oH_Period, 4095);
      frame(VA, -1, 1'b0);
      frame(VA, -1, 1'b1);
      chk("to_relock_wait", vif.oLock, 0);
      frame(VA, -1, 1'b1);
      chk("to_relock", vif.oLock, 1);

      for (int p = 0; p < 5; p++) pix(p, HA, 1'b0, 0, 1'b1);
      rstStep();
      rstZero("midrst");
      chk("midrst_err", vif.oErr, 0);
      for (int p = 5; p < LINE; p++) pix(p, HA, 1'b0, 0, 1'b1);
      for (int l = 1; l < VA + 4; l++)
         line(l < VA ? HA : 0, (l == VA + 1) || (l == VA + 2), l, 1'b1);
      frame(VA, -1, 1'b0);
      chk("midrst_wait", vif.oLock, 0);
      frame(VA, -1, 1'b1);
      chk("midrst_relock", vif.oLock, 1);

      frame(VA, 1, 1'b0);
      frame(VA, -1, 1'b1);
      errCnt = 0;
      frame(VA + 1, -1, 1'b0);
      chk("tall_err", errCnt, 1);
      chk("tall_vlines", vif.oV_Lines, 5);
      frame(VA, -1, 1'b1);
      chk("tall_gf_clr", vif.oLock, 0);
      frame(VA, -1, 1'b0);
      chk("tall_relock", vif.oLock, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
